// File: rtl/washer_pwm_capture.sv
// Servo PWM capture: measures high time and period of each pulse, decodes UP/DOWN, flags bad/missing signal.
// Latency: valid/errPulse are registered one cycle after the synchronized closing rise; no backpressure (strobes only).
module washer_pwm_capture #(
  parameter int CNT_W      = 10,
  parameter int THRESH     = 72,
  parameter int PERIOD_MIN = 900,
  parameter int PERIOD_MAX = 1000,
  parameter int TIMEOUT    = 1023
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             pwmIn,
  output logic [CNT_W-1:0] widthOut,
  output logic [CNT_W-1:0] periodOut,
  output logic             valid,
  output logic             servoDown,
  output logic             errPulse,
  output logic             noSignal
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] PMIN_C  = CNT_W'(PERIOD_MIN);
  localparam logic [CNT_W-1:0] PMAX_C  = CNT_W'(PERIOD_MAX);
  localparam logic [CNT_W-1:0] THR_C   = CNT_W'(THRESH);

  logic             s1_q, s2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hiw_q, hiw_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             down_q, down_d;
  logic             nosig_q, nosig_d;
  state_t           state_q, state_d;
  logic             rise, fall, accept;

  always_comb begin
    rise   = s2_q & ~prev_q;
    fall   = ~s2_q & prev_q;
    // cnt_q is the closing period here, hiw_q the high time captured on the fall
    accept = (cnt_q >= PMIN_C) && (cnt_q <= PMAX_C) &&
             (hiw_q != '0) && (hiw_q < cnt_q);

    cnt_d    = rise ? CNT_W'(1) : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1));
    hiw_d    = hiw_q;
    width_d  = width_q;
    period_d = period_q;
    down_d   = down_q;
    nosig_d  = nosig_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    state_d  = state_q;

    case (state_q)
      IDLE: begin
        if (rise) state_d = HIGH;
      end
      HIGH: begin
        if (fall) begin
          hiw_d   = cnt_q;
          state_d = LOW;
        end else if (cnt_q == TO_C) begin
          nosig_d = 1'b1;
          state_d = IDLE;
        end
      end
      LOW: begin
        if (rise) begin
          state_d = HIGH;
          if (accept) begin
            width_d  = hiw_q;
            period_d = cnt_q;
            down_d   = (hiw_q < THR_C);
            valid_d  = 1'b1;
            nosig_d  = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else if (cnt_q == TO_C) begin
          nosig_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      // Synchronizer presets high so a line already high at release is not a rise
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      prev_q   <= 1'b1;
      cnt_q    <= '0;
      hiw_q    <= '0;
      width_q  <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      down_q   <= 1'b0;
      nosig_q  <= 1'b0;
      state_q  <= IDLE;
    end else begin
      s1_q     <= pwmIn;
      s2_q     <= s1_q;
      prev_q   <= s2_q;
      cnt_q    <= cnt_d;
      hiw_q    <= hiw_d;
      width_q  <= width_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      down_q   <= down_d;
      nosig_q  <= nosig_d;
      state_q  <= state_d;
    end
  end

  assign widthOut  = width_q;
  assign periodOut = period_q;
  assign valid     = valid_q;
  assign errPulse  = err_q;
  assign servoDown = down_q;
  assign noSignal  = nosig_q;

endmodule
